pkt_fifo_writer: RTL and testbench



---
 rtl/pkt_fifo_pkg.sv | 12 +
 rtl/sat_counter.sv | 29 ++
 rtl/pkt_fifo_writer.sv | 140 ++++++++++++++
 tb/tb_pkt_fifo_writer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_fifo_pkg.sv
// Shared types and constants for the packet FIFO writer.
package pkt_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  localparam logic [15:0] FRAMING_ERR_MAX = 16'hFFFF;

endpackage

// File: rtl/sat_counter.sv
// Event counter that either wraps or sticks at all-ones.
module sat_counter #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_max;

  assign at_max = SATURATE && (count_q == {WIDTH{1'b1}});

  always_comb begin
    count_d = count_q;
    if (inc_i && !at_max) count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pkt_fifo_writer.sv
// Avalon-ST to FIFO write-side bridge: enforces packet framing and turns
// FIFO almost_full into either source stalls or whole-packet drops.
//
// state | meaning
// IDLE  | between packets, waiting for SOP
// PKT   | forwarding the body of a packet
// DROP  | discarding beats until EOP
module pkt_fifo_writer
  import pkt_fifo_pkg::*;
#(
  parameter int SYMBOLS_PER_BEAT = 64,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int DROP_ON_FULL     = 0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0] s_data,
  input  logic                                        s_valid,
  output logic                                        s_ready,
  input  logic                                        s_startofpacket,
  input  logic                                        s_endofpacket,
  input  logic [$clog2(SYMBOLS_PER_BEAT)-1:0]         s_empty,
  output logic [SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0] m_data,
  output logic                                        m_valid,
  output logic                                        m_startofpacket,
  output logic                                        m_endofpacket,
  output logic [$clog2(SYMBOLS_PER_BEAT)-1:0]         m_empty,
  input  logic                                        m_almost_full,
  input  logic                                        m_overflow,
  output logic [31:0]                                 pkt_count,
  output logic [31:0]                                 drop_count,
  output logic [15:0]                                 framing_err_count,
  output logic                                        overflow_seen
);

  localparam int DW     = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL;
  localparam int EW     = $clog2(SYMBOLS_PER_BEAT);
  localparam int FERR_W = $bits(FRAMING_ERR_MAX);
  localparam bit DROP_MODE = (DROP_ON_FULL != 0);

  // Beat layout follows the module parameters, so it is declared locally.
  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [DW-1:0] data;
  } beat_t;

  wr_state_t state_q, state_d;
  beat_t     beat_q, beat_d;
  logic      valid_q, valid_d;
  logic      run_q;
  logic      overflow_q;
  logic      accept;
  logic      inc_pkt, inc_drop, inc_ferr;

  assign s_ready = run_q & (DROP_MODE | ~m_almost_full);
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d      = state_q;
    valid_d      = 1'b0;
    beat_d       = beat_q;
    beat_d.sop   = 1'b0;
    beat_d.eop   = 1'b0;
    inc_drop     = 1'b0;
    inc_ferr     = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (!s_startofpacket) begin
            inc_ferr = 1'b1;
          end else if (DROP_MODE && m_almost_full) begin
            inc_drop = 1'b1;
            state_d  = s_endofpacket ? IDLE : DROP;
          end else begin
            valid_d = 1'b1;
            beat_d  = '{sop: 1'b1, eop: s_endofpacket, empty: s_empty, data: s_data};
            state_d = s_endofpacket ? IDLE : PKT;
          end
        end
        PKT: begin
          valid_d = 1'b1;
          if (s_startofpacket) begin
            // A new SOP mid-packet: close the old packet here and discard the new one.
            beat_d   = '{sop: 1'b0, eop: 1'b1, empty: '0, data: s_data};
            inc_ferr = 1'b1;
            state_d  = DROP;
          end else begin
            beat_d  = '{sop: 1'b0, eop: s_endofpacket, empty: s_empty, data: s_data};
            state_d = s_endofpacket ? IDLE : PKT;
          end
        end
        DROP: begin
          inc_ferr = s_startofpacket;
          if (s_endofpacket) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign inc_pkt = valid_d & beat_d.eop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      valid_q    <= 1'b0;
      run_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      valid_q    <= valid_d;
      run_q      <= 1'b1;
      overflow_q <= overflow_q | m_overflow;
    end
  end

  assign m_data          = beat_q.data;
  assign m_empty         = beat_q.empty;
  assign m_startofpacket = beat_q.sop;
  assign m_endofpacket   = beat_q.eop;
  assign m_valid         = valid_q;
  assign overflow_seen   = overflow_q;

  sat_counter #(.WIDTH(32), .SATURATE(1'b0)) u_pkt_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(inc_pkt), .count_o(pkt_count)
  );

  sat_counter #(.WIDTH(32), .SATURATE(1'b0)) u_drop_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(inc_drop), .count_o(drop_count)
  );

  sat_counter #(.WIDTH(FERR_W), .SATURATE(1'b1)) u_ferr_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(inc_ferr), .count_o(framing_err_count)
  );

endmodule

// File: tb/tb_pkt_fifo_writer.sv
// Directed bench for pkt_fifo_writer: a stall-mode and a drop-mode instance share the source stimulus.
module tb_pkt_fifo_writer;

  localparam int DW = 512;
  localparam int EW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0;
  logic [EW-1:0] s_empty = '0;
  logic          af0 = 1'b0, af1 = 1'b0, ovf = 1'b0;

  logic          s_ready0, m_valid0, m_sop0, m_eop0, ovs0;
  logic [DW-1:0] m_data0;
  logic [EW-1:0] m_empty0;
  logic [31:0]   pkt0, drop0;
  logic [15:0]   ferr0;
  logic          s_ready1, m_valid1, m_sop1, m_eop1, ovs1;
  logic [DW-1:0] m_data1;
  logic [EW-1:0] m_empty1;
  logic [31:0]   pkt1, drop1;
  logic [15:0]   ferr1;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [DW-1:0] data;
    int            cyc;
  } rec_t;

  rec_t mon0[$];
  rec_t mon1[$];
  int   acc0[$];

  pkt_fifo_writer #(.SYMBOLS_PER_BEAT(64), .BITS_PER_SYMBOL(8), .DROP_ON_FULL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
    .s_startofpacket(s_sop), .s_endofpacket(s_eop), .s_empty(s_empty),
    .m_data(m_data0), .m_valid(m_valid0), .m_startofpacket(m_sop0), .m_endofpacket(m_eop0),
    .m_empty(m_empty0), .m_almost_full(af0), .m_overflow(ovf), .pkt_count(pkt0),
    .drop_count(drop0), .framing_err_count(ferr0), .overflow_seen(ovs0)
  );

  pkt_fifo_writer #(.SYMBOLS_PER_BEAT(64), .BITS_PER_SYMBOL(8), .DROP_ON_FULL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
    .s_startofpacket(s_sop), .s_endofpacket(s_eop), .s_empty(s_empty),
    .m_data(m_data1), .m_valid(m_valid1), .m_startofpacket(m_sop1), .m_endofpacket(m_eop1),
    .m_empty(m_empty1), .m_almost_full(af1), .m_overflow(ovf), .pkt_count(pkt1),
    .drop_count(drop1), .framing_err_count(ferr1), .overflow_seen(ovs1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid0 === 1'b1) mon0.push_back('{m_sop0, m_eop0, m_empty0, m_data0, cyc});
    if (m_valid1 === 1'b1) mon1.push_back('{m_sop1, m_eop1, m_empty1, m_data1, cyc});
  end

  function automatic logic [DW-1:0] mk_data(input logic [31:0] tag);
    return {{(DW-32){1'b0}}, tag};
  endfunction

  task automatic do_reset;
    s_valid = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon0.delete();
    mon1.delete();
    acc0.delete();
  endtask

  task automatic send_beat(input bit sel, input bit b_sop, input bit b_eop,
                           input logic [EW-1:0] b_empty, input logic [31:0] tag);
    bit ok;
    bit done;
    s_data  = mk_data(tag);
    s_sop   = b_sop;
    s_eop   = b_eop;
    s_empty = b_empty;
    s_valid = 1'b1;
    done    = 1'b0;
    #1;
    for (int n = 0; n < 100 && !done; n++) begin
      ok = sel ? s_ready1 : s_ready0;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL send_timeout: tag=%h not accepted in 100 cycles (want accepted)", tag);
    end else if (!sel) begin
      acc0.push_back(cyc);
    end
    s_valid = 1'b0;
  endtask

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #3;
    total++;
    if ({s_ready0, m_valid0, m_sop0, m_eop0} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes: got %b want 0000", {s_ready0, m_valid0, m_sop0, m_eop0});
    end
    total++;
    if (m_data0 !== '0 || m_empty0 !== '0) begin
      bad++; $display("FAIL reset_data: data=%h empty=%0d want 0", m_data0[31:0], m_empty0);
    end
    total++;
    if (pkt0 !== 0 || drop0 !== 0 || ferr0 !== 0 || ovs0 !== 1'b0) begin
      bad++; $display("FAIL reset_counters: pkt=%0d drop=%0d ferr=%0d ovs=%b want 0", pkt0, drop0, ferr0, ovs0);
    end
    do_reset();
    #1;
    total++;
    if (s_ready0 !== 1'b0) begin
      bad++; $display("FAIL ready_after_release: got %b want 0", s_ready0);
    end
    @(posedge clk);
    #1;
    total++;
    if (s_ready0 !== 1'b1) begin
      bad++; $display("FAIL ready_one_cycle_later: got %b want 1", s_ready0);
    end
  endtask

  task automatic test_basic;
    logic [31:0] tag;
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 4; b++)
        send_beat(1'b0, b == 0, b == 3, (b == 3) ? EW'(3 + p) : '0, 32'h100 + 32'(p * 16 + b));
    settle();
    total++;
    if (mon0.size() != 12 || acc0.size() != 12) begin
      bad++; $display("FAIL basic_count: beats=%0d accepts=%0d want 12", mon0.size(), acc0.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        tag = 32'h100 + 32'((i / 4) * 16 + (i % 4));
        total++;
        if (mon0[i].data !== mk_data(tag) || mon0[i].sop !== ((i % 4) == 0) ||
            mon0[i].eop !== ((i % 4) == 3) ||
            mon0[i].empty !== (((i % 4) == 3) ? EW'(3 + i / 4) : EW'(0)) ||
            mon0[i].cyc != acc0[i]) begin
          bad++;
          $display("FAIL basic_beat%0d: tag=%h sop=%b eop=%b empty=%0d cyc=%0d want tag=%h accept_cyc=%0d",
                   i, mon0[i].data[31:0], mon0[i].sop, mon0[i].eop, mon0[i].empty, mon0[i].cyc, tag, acc0[i]);
        end
      end
    end
    total++;
    if (pkt0 !== 32'd3) begin
      bad++; $display("FAIL basic_pkt_count: got %0d want 3", pkt0);
    end
  endtask

  task automatic test_stall;
    int low;
    do_reset();
    send_beat(1'b0, 1'b1, 1'b0, '0, 32'h200);
    send_beat(1'b0, 1'b0, 1'b0, '0, 32'h201);
    s_data  = mk_data(32'h202);
    s_sop   = 1'b0;
    s_eop   = 1'b0;
    s_empty = '0;
    s_valid = 1'b1;
    af0     = 1'b1;
    low     = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_ready0 === 1'b0) low++;
      @(posedge clk);
      #1;
    end
    af0 = 1'b0;
    total++;
    if (low != 10) begin
      bad++; $display("FAIL stall_ready_low: low cycles=%0d want 10", low);
    end
    @(negedge clk);
    total++;
    if (s_ready0 !== 1'b1 || mon0.size() != 2) begin
      bad++; $display("FAIL stall_release: ready=%b beats=%0d want ready=1 beats=2", s_ready0, mon0.size());
    end
    send_beat(1'b0, 1'b0, 1'b0, '0, 32'h202);
    send_beat(1'b0, 1'b0, 1'b0, '0, 32'h203);
    send_beat(1'b0, 1'b0, 1'b1, 6'd7, 32'h204);
    settle();
    total++;
    if (mon0.size() != 5) begin
      bad++; $display("FAIL stall_beats: got %0d want 5", mon0.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (mon0[i].data !== mk_data(32'h200 + 32'(i)) || mon0[i].sop !== (i == 0) ||
            mon0[i].eop !== (i == 4) || mon0[i].empty !== ((i == 4) ? 6'd7 : 6'd0)) begin
          bad++; $display("FAIL stall_beat%0d: tag=%h sop=%b eop=%b empty=%0d want tag=%h",
                          i, mon0[i].data[31:0], mon0[i].sop, mon0[i].eop, mon0[i].empty, 32'h200 + 32'(i));
        end
      end
    end
    total++;
    if (pkt0 !== 32'd1 || drop0 !== 32'd0) begin
      bad++; $display("FAIL stall_counters: pkt=%0d drop=%0d want 1 0", pkt0, drop0);
    end
  endtask

  task automatic test_drop;
    do_reset();
    af1 = 1'b1;
    send_beat(1'b1, 1'b1, 1'b0, '0, 32'h300);
    af1 = 1'b0;
    for (int b = 1; b < 6; b++) send_beat(1'b1, 1'b0, b == 5, '0, 32'h300 + 32'(b));
    for (int b = 0; b < 3; b++) send_beat(1'b1, b == 0, b == 2, (b == 2) ? 6'd2 : 6'd0, 32'h310 + 32'(b));
    settle();
    total++;
    if (mon1.size() != 3) begin
      bad++; $display("FAIL drop_beats: got %0d want 3", mon1.size());
    end else begin
      total++;
      if (mon1[0].data !== mk_data(32'h310) || mon1[0].sop !== 1'b1 ||
          mon1[2].eop !== 1'b1 || mon1[2].empty !== 6'd2) begin
        bad++; $display("FAIL drop_next_pkt: first tag=%h sop=%b last eop=%b empty=%0d want 310 1 1 2",
                        mon1[0].data[31:0], mon1[0].sop, mon1[2].eop, mon1[2].empty);
      end
    end
    total++;
    if (drop1 !== 32'd1 || pkt1 !== 32'd1 || ferr1 !== 16'd0) begin
      bad++; $display("FAIL drop_counters: drop=%0d pkt=%0d ferr=%0d want 1 1 0", drop1, pkt1, ferr1);
    end
  endtask

  task automatic test_framing;
    do_reset();
    send_beat(1'b0, 1'b0, 1'b0, '0, 32'h400);
    settle();
    total++;
    if (ferr0 !== 16'd1 || mon0.size() != 0) begin
      bad++; $display("FAIL framing_stray: ferr=%0d beats=%0d want 1 0", ferr0, mon0.size());
    end
    send_beat(1'b0, 1'b1, 1'b0, '0, 32'h410);
    send_beat(1'b0, 1'b0, 1'b0, '0, 32'h411);
    send_beat(1'b0, 1'b1, 1'b0, 6'd5, 32'h412);
    send_beat(1'b0, 1'b0, 1'b0, '0, 32'h413);
    send_beat(1'b0, 1'b0, 1'b1, 6'd1, 32'h414);
    send_beat(1'b0, 1'b1, 1'b0, '0, 32'h420);
    send_beat(1'b0, 1'b0, 1'b1, 6'd4, 32'h421);
    settle();
    total++;
    if (mon0.size() != 5) begin
      bad++; $display("FAIL framing_beats: got %0d want 5", mon0.size());
    end else begin
      total++;
      if (mon0[2].data !== mk_data(32'h412) || mon0[2].sop !== 1'b0 ||
          mon0[2].eop !== 1'b1 || mon0[2].empty !== 6'd0) begin
        bad++; $display("FAIL framing_forced_eop: tag=%h sop=%b eop=%b empty=%0d want 412 0 1 0",
                        mon0[2].data[31:0], mon0[2].sop, mon0[2].eop, mon0[2].empty);
      end
      total++;
      if (mon0[3].data !== mk_data(32'h420) || mon0[3].sop !== 1'b1 || mon0[4].eop !== 1'b1) begin
        bad++; $display("FAIL framing_recover: tag=%h sop=%b eop=%b want 420 1 1",
                        mon0[3].data[31:0], mon0[3].sop, mon0[4].eop);
      end
    end
    total++;
    if (ferr0 !== 16'd2 || pkt0 !== 32'd2) begin
      bad++; $display("FAIL framing_counters: ferr=%0d pkt=%0d want 2 2", ferr0, pkt0);
    end
  endtask

  task automatic test_single_and_reset;
    do_reset();
    for (int i = 0; i < 10; i++) send_beat(1'b0, 1'b1, 1'b1, 6'(i), 32'h500 + 32'(i));
    settle();
    total++;
    if (pkt0 !== 32'd10 || mon0.size() != 10) begin
      bad++; $display("FAIL single_count: pkt=%0d beats=%0d want 10 10", pkt0, mon0.size());
    end
    send_beat(1'b0, 1'b1, 1'b0, '0, 32'h600);
    send_beat(1'b0, 1'b0, 1'b0, 6'd9, 32'h601);
    total++;
    if (m_valid0 !== 1'b1) begin
      bad++; $display("FAIL midpkt_valid: got %b want 1", m_valid0);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({s_ready0, m_valid0, m_sop0, m_eop0} !== 4'b0000 || m_data0 !== '0 || m_empty0 !== '0) begin
      bad++; $display("FAIL async_reset_outputs: strobes=%b data=%h empty=%0d want 0",
                      {s_ready0, m_valid0, m_sop0, m_eop0}, m_data0[31:0], m_empty0);
    end
    total++;
    if (pkt0 !== 0 || ferr0 !== 0 || drop0 !== 0) begin
      bad++; $display("FAIL async_reset_counters: pkt=%0d ferr=%0d drop=%0d want 0", pkt0, ferr0, drop0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (s_ready0 !== 1'b0) begin
      bad++; $display("FAIL midpkt_ready_release: got %b want 0", s_ready0);
    end
    @(posedge clk);
    #1;
    total++;
    if (s_ready0 !== 1'b1) begin
      bad++; $display("FAIL midpkt_ready_run: got %b want 1", s_ready0);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    @(posedge clk);
    #1;
    total++;
    if (ovs0 !== 1'b0) begin
      bad++; $display("FAIL overflow_pre: got %b want 0", ovs0);
    end
    ovf = 1'b1;
    @(posedge clk);
    #1;
    ovf = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (ovs0 !== 1'b1 || ovs1 !== 1'b1) begin
      bad++; $display("FAIL overflow_sticky: got %b%b want 11", ovs0, ovs1);
    end
    do_reset();
    total++;
    if (ovs0 !== 1'b0) begin
      bad++; $display("FAIL overflow_reset: got %b want 0", ovs0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_drop();
    test_framing();
    test_single_and_reset();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
